// File: rtl/ppt_pulse_gen.sv
// PPT firing controller: prescaled tick base, shadowed burst parameters, trigger pulse train.
// Optional PPT_CHARGE_EN adds a registered charge_en output for the capacitor charger.
module ppt_pulse_gen #(
  parameter int PRESC_W = 24,
  parameter int TW      = 15
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [4:0]    clk_div,
  input  logic [TW-1:0] period,
  input  logic [TW-1:0] width,
  input  logic [7:0]    count,
  input  logic          run_ppt,
  output logic          pulse_out,
  output logic [7:0]    count_done,
  output logic          done
`ifdef PPT_CHARGE_EN
  ,
  output logic          charge_en
`endif
);

  // state   | meaning
  // IDLE    | waiting for run_ppt; shadows latched on start
  // PULSE   | trigger high, counting W ticks
  // GAP     | trigger low, counting up to P ticks for the firing
  // DONE    | burst finished, done held until run_ppt drops

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;

  localparam logic [4:0]    D_MAX = 5'(PRESC_W - 1);
  localparam logic [TW-1:0] P_MIN = TW'(2);
  localparam logic [TW-1:0] ONE_T = TW'(1);

  state_t               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [4:0]           d_q, d_d;
  logic [TW-1:0]        p_q, p_d;
  logic [TW-1:0]        w_q, w_d;
  logic [7:0]           n_q, n_d;
  logic [7:0]           count_done_q, count_done_d;
  logic                 done_q, done_d;
  logic                 pulse_out_q, pulse_out_d;
  logic                 first_q, first_d;

  logic [4:0]           d_in;
  logic [TW-1:0]        p_in;
  logic [TW-1:0]        w_in;
  logic [PRESC_W-1:0]   presc_mask;
  logic                 active;
  logic                 tick;
  logic [TW-1:0]        cnt_inc;
  logic [7:0]           cd_inc;
  logic                 last_fire;

  assign d_in = (clk_div > D_MAX) ? D_MAX : clk_div;
  assign p_in = (period < P_MIN) ? P_MIN : period;
  assign w_in = (width > (p_in - ONE_T)) ? (p_in - ONE_T) : width;

  assign presc_mask = {PRESC_W{1'b1}} >> (D_MAX - d_q);
  assign active     = (state_q == S_PULSE) || (state_q == S_GAP);
  assign tick       = active && ((presc_q & presc_mask) == presc_mask);
  assign cnt_inc    = cnt_q + ONE_T;
  assign cd_inc     = count_done_q + 8'd1;
  assign last_fire  = (cd_inc == n_q);

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    d_d          = d_q;
    p_d          = p_q;
    w_d          = w_q;
    n_d          = n_q;
    count_done_d = count_done_q;
    first_d      = 1'b0;
    pulse_out_d  = 1'b0;
    done_d       = 1'b0;

    // The start cycle holds the prescaler so the first tick lands one full
    // tick period after pulse_out rises.
    if (active && !first_q) begin
      presc_d = presc_q + PRESC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (run_ppt) begin
          d_d          = d_in;
          p_d          = p_in;
          w_d          = w_in;
          n_d          = count;
          presc_d      = '0;
          cnt_d        = '0;
          count_done_d = '0;
          first_d      = 1'b1;
          if (count == 8'd0) begin
            state_d = S_DONE;
          end else if (w_in != '0) begin
            state_d = S_PULSE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_PULSE: begin
        if (!run_ppt) begin
          state_d = S_IDLE;
        end else begin
          pulse_out_d = 1'b1;
          if (tick) begin
            cnt_d = cnt_inc;
            if (cnt_inc == w_q) begin
              state_d     = S_GAP;
              pulse_out_d = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        if (!run_ppt) begin
          state_d = S_IDLE;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == p_q) begin
            count_done_d = cd_inc;
            cnt_d        = '0;
            if (last_fire) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (w_q != '0) begin
              state_d     = S_PULSE;
              pulse_out_d = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        if (run_ppt) begin
          done_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      cnt_q        <= '0;
      d_q          <= '0;
      p_q          <= '0;
      w_q          <= '0;
      n_q          <= '0;
      count_done_q <= '0;
      done_q       <= 1'b0;
      pulse_out_q  <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      p_q          <= p_d;
      w_q          <= w_d;
      n_q          <= n_d;
      count_done_q <= count_done_d;
      done_q       <= done_d;
      pulse_out_q  <= pulse_out_d;
      first_q      <= first_d;
    end
  end

  assign pulse_out  = pulse_out_q;
  assign count_done = count_done_q;
  assign done       = done_q;

`ifdef PPT_CHARGE_EN
  logic charge_en_q, charge_en_d;

  // Charge only while another pulse follows, dropping one tick before it.
  always_comb begin
    charge_en_d = 1'b0;
    if ((state_q != S_IDLE) && (state_d == S_GAP) && (w_q != '0) && !last_fire &&
        (cnt_d < (p_q - ONE_T))) begin
      charge_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      charge_en_q <= 1'b0;
    end else begin
      charge_en_q <= charge_en_d;
    end
  end

  assign charge_en = charge_en_q;
`endif

endmodule
